// File: rtl/irq_seq_pkg.sv
// Shared definitions for the interrupt sequencer: FSM state encoding,
// default vector stride and an id-width helper.
package irq_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      SERV = 2'b10
   } state_t;

   localparam int VEC_STR_DEF = 4;

   // Width of an index into n items; never less than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: valid=1 when any request is set,
// id = index of the lowest set request.
module irq_prio_enc
   import irq_seq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]              req,
   output logic                      valid,
   output logic [id_width(N)-1:0]    id
);

   localparam int IDW = id_width(N);

   always_comb begin
      valid = |req;
      id    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/irq_sequencer.sv
// Prioritised edge-triggered interrupt sequencer with irq_req/irq_ack handshake.
// Define IRQ_NEST_EN to allow higher-priority preemption through a DEPTH-entry id stack.
module irq_sequencer
   import irq_seq_pkg::*;
#(
   parameter int          NSRC     = 8,
   parameter logic [31:0] VEC_BASE = 32'h0000_0018,
   parameter int          VEC_STR  = VEC_STR_DEF,
   parameter int          DEPTH    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NSRC-1:0]             irq_in,
   input  logic                        mask_we,
   input  logic [NSRC-1:0]             mask_wdata,
   input  logic                        cpsr_i,
   input  logic                        irq_ack,
   input  logic                        eoi,
   output logic                        irq_req,
   output logic [31:0]                 irq_vec,
   output logic [id_width(NSRC)-1:0]   irq_id,
   output logic                        in_service,
   output logic [NSRC-1:0]             pending,
   output logic [NSRC-1:0]             mask
);

   localparam int IDW = id_width(NSRC);

   state_t            state_reg, state_next;
   logic [NSRC-1:0]   hist_reg, pending_reg, pending_next, mask_reg;
   logic [IDW-1:0]    id_reg, id_next;
   logic [31:0]       vec_reg, vec_next;
   logic              in_service_reg, in_service_next;
   logic [NSRC-1:0]   rise, clr, eligible;
   logic              elig_valid;
   logic [IDW-1:0]    winner;

   function automatic logic [31:0] vec_of(input logic [IDW-1:0] id);
      return VEC_BASE + 32'(id) * 32'(VEC_STR);
   endfunction

   // Fresh edges are eligible in the cycle they arrive, giving one-cycle request latency.
   assign rise     = irq_in & ~hist_reg;
   assign eligible = (pending_reg | rise) & ~mask_reg;

   irq_prio_enc #(.N(NSRC)) u_prio (
      .req   (eligible),
      .valid (elig_valid),
      .id    (winner)
   );

`ifdef IRQ_NEST_EN
   localparam int SPW = $clog2(DEPTH + 1);
   localparam int AW  = id_width(DEPTH);

   logic [IDW-1:0] stack_reg [DEPTH];
   logic [SPW-1:0] sp_reg;
   logic [IDW-1:0] serv_id_reg, serv_id_next;
   logic           push, pop;
   logic [AW-1:0]  top_idx, push_idx;

   assign top_idx  = AW'(sp_reg - 1'b1);
   assign push_idx = AW'(sp_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_reg      <= '0;
         serv_id_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            stack_reg[i] <= '0;
         end
      end else begin
         serv_id_reg <= serv_id_next;
         if (push) begin
            stack_reg[push_idx] <= serv_id_reg;
            sp_reg              <= sp_reg + 1'b1;
         end else if (pop) begin
            sp_reg <= sp_reg - 1'b1;
         end
      end
   end
`else
   logic unused_depth;
   assign unused_depth = (DEPTH > 0);
`endif

   always_comb begin
      state_next      = state_reg;
      id_next         = id_reg;
      vec_next        = vec_reg;
      in_service_next = in_service_reg;
      clr             = '0;
`ifdef IRQ_NEST_EN
      serv_id_next    = serv_id_reg;
      push            = 1'b0;
      pop             = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (elig_valid && !cpsr_i) begin
               id_next    = winner;
               vec_next   = vec_of(winner);
               state_next = REQ;
            end
         end
         REQ: begin
            if (irq_ack) begin
               clr             = NSRC'(1) << id_reg;
               in_service_next = 1'b1;
               state_next      = SERV;
`ifdef IRQ_NEST_EN
               // A request raised while already in service is a preemption.
               push            = in_service_reg;
               serv_id_next    = id_reg;
`endif
            end
         end
         SERV: begin
`ifdef IRQ_NEST_EN
            if (eoi) begin
               if (sp_reg != '0) begin
                  pop          = 1'b1;
                  id_next      = stack_reg[top_idx];
                  vec_next     = vec_of(stack_reg[top_idx]);
                  serv_id_next = stack_reg[top_idx];
               end else begin
                  in_service_next = 1'b0;
                  state_next      = IDLE;
               end
            end else if (elig_valid && (winner < serv_id_reg) && (sp_reg != SPW'(DEPTH))) begin
               id_next    = winner;
               vec_next   = vec_of(winner);
               state_next = REQ;
            end
`else
            if (eoi) begin
               in_service_next = 1'b0;
               state_next      = IDLE;
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // A new edge on the acknowledge cycle wins over the clear.
   assign pending_next = (pending_reg & ~clr) | rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         hist_reg       <= irq_in;
         pending_reg    <= '0;
         mask_reg       <= '1;
         id_reg         <= '0;
         vec_reg        <= VEC_BASE;
         in_service_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         hist_reg       <= irq_in;
         pending_reg    <= pending_next;
         id_reg         <= id_next;
         vec_reg        <= vec_next;
         in_service_reg <= in_service_next;
         if (mask_we) begin
            mask_reg <= mask_wdata;
         end
      end
   end

   assign irq_req    = (state_reg == REQ);
   assign irq_vec    = vec_reg;
   assign irq_id     = id_reg;
   assign in_service = in_service_reg;
   assign pending    = pending_reg;
   assign mask       = mask_reg;

endmodule
